// File: rtl/grf_hazard_pkg.sv
// Shared definitions for the GRF hazard controller: forward-select codes,
// the "operand unused" Tuse value, mult/div op encodings and the per-stage
// scoreboard entry.
package grf_hazard_pkg;

  // D-stage forward selects
  localparam logic [1:0] FWD_GRF   = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;

  // E-stage forward selects
  localparam logic [1:0] EFWD_PIPE = 2'd0;
  localparam logic [1:0] EFWD_M    = 2'd1;
  localparam logic [1:0] EFWD_W    = 2'd2;

  // Tuse value meaning "this operand is never read"
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Youngest-match select returned by grf_hazard_match
  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_S0    = 2'd1;
  localparam logic [1:0] SEL_S1    = 2'd2;
  localparam logic [1:0] SEL_S2    = 2'd3;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_op_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
  } stage_t;

  // Tnew counts down by one per stage and never goes below zero
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/grf_hazard_match.sv
// Youngest-match / stall / ready computation for one source register
// against up to three older pipeline entries (s0 youngest, s2 oldest).
module grf_hazard_match
  import grf_hazard_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [1:0] tuse_i,
  input  stage_t     s0_i,
  input  stage_t     s1_i,
  input  stage_t     s2_i,
  output logic [1:0] sel_o,
  output logic       rdy_o,
  output logic       stall_o
);

  logic [1:0] tnew_w;

  // pick the youngest stage whose destination equals the (non-zero) source
  always_comb begin
    sel_o  = SEL_NONE;
    tnew_w = 2'd0;
    if (src_i != 5'd0) begin
      if (s0_i.valid && s0_i.dst == src_i) begin
        sel_o  = SEL_S0;
        tnew_w = s0_i.tnew;
      end else if (s1_i.valid && s1_i.dst == src_i) begin
        sel_o  = SEL_S1;
        tnew_w = s1_i.tnew;
      end else if (s2_i.valid && s2_i.dst == src_i) begin
        sel_o  = SEL_S2;
        tnew_w = s2_i.tnew;
      end
    end
  end

  assign rdy_o   = (sel_o != SEL_NONE) && (tnew_w == 2'd0);
  assign stall_o = (sel_o != SEL_NONE) && (tnew_w > tuse_i);

endmodule

// File: rtl/grf_hazard_ctrl.sv
// Scoreboard and hazard controller for the 32-entry GRF of the 5-stage
// MIPS pipeline. Tracks E/M/W destinations with their Tnew and the mult/div
// busy counter; produces the D stall and the D/E forward selects.
// W->D is covered by GRF write-through, so D never forwards from W.
// Optional build macro: HAZARD_TRACE_EN prints every stalled cycle.
module grf_hazard_ctrl
  import grf_hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_use,
  input  logic [1:0] d_md_op,
  output logic       stall,
  output logic [1:0] d_fwd_rs,
  output logic [1:0] d_fwd_rt,
  output logic [1:0] e_fwd_rs,
  output logic [1:0] e_fwd_rt,
  output logic       md_busy
);

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  stage_t           e_q, m_q, w_q;
  logic [4:0]       e_rs_q, e_rt_q;
  logic [1:0]       e_md_q;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic [1:0] d_rs_sel, d_rt_sel, e_rs_sel, e_rt_sel;
  logic       d_rs_rdy, d_rt_rdy, e_rs_rdy, e_rt_rdy;
  logic       d_rs_stall, d_rt_stall, e_rs_stall, e_rt_stall;
  logic       md_stall, e_md_start, capture;
  logic       unused_e_stall;

  grf_hazard_match u_d_rs (
    .src_i(d_rs), .tuse_i(d_rs_tuse), .s0_i(e_q), .s1_i(m_q), .s2_i(w_q),
    .sel_o(d_rs_sel), .rdy_o(d_rs_rdy), .stall_o(d_rs_stall)
  );

  grf_hazard_match u_d_rt (
    .src_i(d_rt), .tuse_i(d_rt_tuse), .s0_i(e_q), .s1_i(m_q), .s2_i(w_q),
    .sel_o(d_rt_sel), .rdy_o(d_rt_rdy), .stall_o(d_rt_stall)
  );

  // E-stage operands are consumed now, so only the select matters here
  grf_hazard_match u_e_rs (
    .src_i(e_rs_q), .tuse_i(TUSE_NONE), .s0_i(m_q), .s1_i(w_q), .s2_i('0),
    .sel_o(e_rs_sel), .rdy_o(e_rs_rdy), .stall_o(e_rs_stall)
  );

  grf_hazard_match u_e_rt (
    .src_i(e_rt_q), .tuse_i(TUSE_NONE), .s0_i(m_q), .s1_i(w_q), .s2_i('0),
    .sel_o(e_rt_sel), .rdy_o(e_rt_rdy), .stall_o(e_rt_stall)
  );

  assign unused_e_stall = e_rs_stall | e_rt_stall;

  assign e_md_start = e_q.valid && (e_md_q != MD_NONE);
  assign md_stall   = d_md_use && ((md_cnt_q != '0) || e_md_start);
  assign stall      = d_valid && (d_rs_stall || d_rt_stall || md_stall);
  assign capture    = d_valid && !stall && !flush;
  assign md_busy    = (md_cnt_q != '0);

  // forward selects derived from the youngest match
  always_comb begin
    d_fwd_rs = FWD_GRF;
    d_fwd_rt = FWD_GRF;
    e_fwd_rs = EFWD_PIPE;
    e_fwd_rt = EFWD_PIPE;
    if (d_rs_rdy && d_rs_sel == SEL_S0) d_fwd_rs = FWD_E;
    else if (d_rs_rdy && d_rs_sel == SEL_S1) d_fwd_rs = FWD_M;
    if (d_rt_rdy && d_rt_sel == SEL_S0) d_fwd_rt = FWD_E;
    else if (d_rt_rdy && d_rt_sel == SEL_S1) d_fwd_rt = FWD_M;
    if (e_rs_rdy && e_rs_sel == SEL_S0) e_fwd_rs = EFWD_M;
    else if (e_rs_sel == SEL_S1) e_fwd_rs = EFWD_W;
    if (e_rt_rdy && e_rt_sel == SEL_S0) e_fwd_rt = EFWD_M;
    else if (e_rt_sel == SEL_S1) e_fwd_rt = EFWD_W;
  end

  // mult/div busy counter: reload on a start leaving E, else count down
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_start) begin
      if (e_md_q == MD_DIV) md_cnt_d = CNT_W'(DIV_CYCLES);
      else                  md_cnt_d = CNT_W'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  // pipeline scoreboard advances every cycle; D enters E only when captured
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_md_q   <= MD_NONE;
      md_cnt_q <= '0;
    end else begin
      w_q      <= '{valid: m_q.valid, dst: m_q.dst, tnew: tnew_dec(m_q.tnew)};
      m_q      <= '{valid: e_q.valid, dst: e_q.dst, tnew: tnew_dec(e_q.tnew)};
      md_cnt_q <= md_cnt_d;
      if (capture) begin
        e_q    <= '{valid: 1'b1, dst: d_dst, tnew: d_tnew};
        e_rs_q <= d_rs;
        e_rt_q <= d_rt;
        e_md_q <= d_md_op;
      end else begin
        e_q    <= '0;
        e_rs_q <= '0;
        e_rt_q <= '0;
        e_md_q <= MD_NONE;
      end
    end
  end

`ifdef HAZARD_TRACE_EN
  // report the cause of every stalled cycle
  always_ff @(posedge clk) begin
    if (stall) begin
      if (d_rs_stall)
        $display("%0t hazard stall: rs $%0d blocked by %s", $time, d_rs,
                 (d_rs_sel == SEL_S0) ? "E" : (d_rs_sel == SEL_S1) ? "M" : "W");
      else if (d_rt_stall)
        $display("%0t hazard stall: rt $%0d blocked by %s", $time, d_rt,
                 (d_rt_sel == SEL_S0) ? "E" : (d_rt_sel == SEL_S1) ? "M" : "W");
      else
        $display("%0t hazard stall: md blocked by %s", $time,
                 e_md_start ? "E" : "MD");
    end
  end
`endif

endmodule
